// File: rtl/note_lookup_arbiter_pkg.sv
// Shared definitions for the note lookup arbiter and its round-robin helper.
package note_lookup_arbiter_pkg;

  // Default widths and the note code that means silence
  localparam int unsigned NOTE_W_DEF    = 6;
  localparam int unsigned PHASE_W_DEF   = 32;
  localparam int unsigned REST_NOTE_DEF = 0;

  // Per-channel vibrato offset width and the lookup wait counter width (latency 0..7)
  localparam int unsigned ADJ_W = 16;
  localparam int unsigned CNT_W = 3;

  // Lookup sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  // Low bit index of element idx in a flattened bus of w-bit elements
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/note_lookup_arbiter_rr_arbiter.sv
// Round-robin search: first set request at or after the pointer, wrapping modulo N.
module note_lookup_arbiter_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             any_c
);

  int unsigned cand;

  // Walk the channels starting at the pointer; the first requester found wins
  always_comb begin
    grant_idx_c = '0;
    any_c       = 1'b0;
    cand        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!any_c && req[IDX_W'(cand)]) begin
        any_c       = 1'b1;
        grant_idx_c = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/note_lookup_arbiter.sv
// Shares one note_table between NUM_CH channel sequencers: round-robin grant,
// lookup with configurable table latency, per-channel held phase delta and ack.
// Optional vibrato offset on the looked-up phase: NOTE_LOOKUP_VIBRATO_EN.
module note_lookup_arbiter
  import note_lookup_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned NOTE_W      = NOTE_W_DEF,
  parameter int unsigned PHASE_W     = PHASE_W_DEF,
  parameter int unsigned LUT_LATENCY = 0,
  parameter int unsigned REST_NOTE   = REST_NOTE_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CH-1:0]           i_req,
  input  logic [NUM_CH*NOTE_W-1:0]    i_note,
  input  logic [NUM_CH*ADJ_W-1:0]     i_adjust,
  output logic [NOTE_W-1:0]           o_lut_note,
  input  logic [PHASE_W-1:0]          i_lut_phase,
  output logic [NUM_CH-1:0]           o_ack,
  output logic [NUM_CH*PHASE_W-1:0]   o_phase_delta,
  output logic                        o_busy
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  state_t              state;
  logic [CH_W-1:0]     ptr;
  logic [CH_W-1:0]     ch_q;
  logic [NOTE_W-1:0]   note_q;
  logic [CNT_W-1:0]    cnt;
  logic                busy_q;

  logic [CH_W-1:0]     grant_idx_c;
  logic                any_c;
  logic [NOTE_W-1:0]   note_sel_c;
  logic [PHASE_W-1:0]  result_c;

  // Round-robin choice among the current requesters
  note_lookup_arbiter_rr_arbiter #(
    .N (NUM_CH)
  ) u_rr (
    .req         (i_req),
    .ptr         (ptr),
    .grant_idx_c (grant_idx_c),
    .any_c       (any_c)
  );

  // Note code of the channel the arbiter would grant this cycle
  always_comb begin
    note_sel_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (CH_W'(k) == grant_idx_c) note_sel_c = i_note[slice_lo(k, NOTE_W) +: NOTE_W];
    end
  end

`ifdef NOTE_LOOKUP_VIBRATO_EN
  logic [ADJ_W-1:0] adj_q;
  logic [ADJ_W-1:0] adj_sel_c;
  logic [ADJ_W-1:0] adj_eff_c;

  // Vibrato offset of the channel the arbiter would grant this cycle
  always_comb begin
    adj_sel_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (CH_W'(k) == grant_idx_c) adj_sel_c = i_adjust[slice_lo(k, ADJ_W) +: ADJ_W];
    end
  end

  // A rest keeps the table's rest value; otherwise add the sign-extended offset
  always_comb begin
    adj_eff_c = (note_q == NOTE_W'(REST_NOTE)) ? '0 : adj_q;
    result_c  = i_lut_phase + PHASE_W'($signed(adj_eff_c));
  end

  // Offset is captured at grant so later requester changes do not leak in
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      adj_q <= '0;
    end else if (state == ST_IDLE && any_c) begin
      adj_q <= adj_sel_c;
    end
  end
`else
  logic unused_c;

  // Without vibrato the table result passes straight through
  always_comb begin
    result_c = i_lut_phase;
  end

  assign unused_c = ^{i_adjust, (note_q == NOTE_W'(REST_NOTE))};
`endif

  // Lookup sequencer; the output slice itself holds the captured result so it
  // updates in the same cycle the ack is visible
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      ch_q          <= '0;
      note_q        <= '0;
      cnt           <= '0;
      busy_q        <= 1'b0;
      o_ack         <= '0;
      o_phase_delta <= '0;
    end else begin
      o_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (any_c) begin
            ch_q   <= grant_idx_c;
            note_q <= note_sel_c;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (cnt == CNT_W'(LUT_LATENCY)) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (CH_W'(k) == ch_q) o_phase_delta[slice_lo(k, PHASE_W) +: PHASE_W] <= result_c;
            end
            o_ack[ch_q] <= 1'b1;
            state       <= ST_WRITE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          ptr    <= (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_lut_note = note_q;
  assign o_busy     = busy_q;

endmodule
